// File: rtl/simple_router_sched.sv
// Credit-based round-robin scheduler feeding the single input of the 4-output router.
// One beat per cycle leaves through registered outputs. Per-output credits keep the downstream buffers from overflowing.
module simple_router_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int CREDITS    = 4,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]          req_addr,
    input  logic [3:0]                    credit_return,
    output logic [DATA_WIDTH-1:0]         sched_din,
    output logic                          sched_din_en,
    output logic [1:0]                    sched_addr,
    output logic [IDW-1:0]                grant_id,
    output logic [15:0]                   credit_cnt,
    output logic                          credit_err
);

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    logic [DATA_WIDTH-1:0] din_q;
    logic                  dinEn_q;
    logic [1:0]            addr_q;
    logic [IDW-1:0]        id_q;
    logic [IDW-1:0]        ptr_q;
    logic                  err_q;
    logic [3:0]            credit_q [4];
    logic [3:0]            credit_d [4];

    logic [NUM_REQ-1:0]    eligible;
    logic                  grantValid;
    logic [IDW-1:0]        grantIdx;
    logic [DATA_WIDTH-1:0] selData;
    logic [1:0]            selAddr;
    logic                  errSet;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (credit_q[req_addr[i*2 +: 2]] != 4'd0);
        end
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx        = 0;
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr_q) + off) % NUM_REQ;
            if (!grantValid && eligible[idx]) begin
                grantValid = 1'b1;
                grantIdx   = IDW'(idx);
            end
        end
        if (!rst) begin
            grantValid = 1'b0;
        end
        req_ready = grantValid ? (NUM_REQ'(1) << grantIdx) : '0;
        selData   = req_data[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
        selAddr   = req_addr[int'(grantIdx)*2 +: 2];
    end

    always_comb begin
        logic dec;
        logic inc;
        dec    = 1'b0;
        inc    = 1'b0;
        errSet = 1'b0;
        for (int k = 0; k < 4; k++) begin
            credit_d[k] = credit_q[k];
            dec = grantValid && (selAddr == 2'(k));
            inc = credit_return[k];
            if (inc && !dec) begin
                if (credit_q[k] == CRED_MAX) begin
                    errSet = 1'b1;
                end else begin
                    credit_d[k] = credit_q[k] + 4'd1;
                end
            end else if (dec && !inc) begin
                credit_d[k] = credit_q[k] - 4'd1;
            end
        end
    end

    // The router expects a zero payload whenever din_en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            din_q   <= '0;
            dinEn_q <= 1'b0;
            addr_q  <= '0;
            id_q    <= '0;
            ptr_q   <= IDW'(NUM_REQ - 1);
            err_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                credit_q[k] <= CRED_MAX;
            end
        end else begin
            if (grantValid) begin
                din_q   <= selData;
                addr_q  <= selAddr;
                dinEn_q <= 1'b1;
                id_q    <= grantIdx;
                ptr_q   <= grantIdx;
            end else begin
                din_q   <= '0;
                dinEn_q <= 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                credit_q[k] <= credit_d[k];
            end
            err_q <= err_q | errSet;
        end
    end

    always_comb begin
        credit_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            credit_cnt[k*4 +: 4] = credit_q[k];
        end
    end

    assign sched_din    = din_q;
    assign sched_din_en = dinEn_q;
    assign sched_addr   = addr_q;
    assign grant_id     = id_q;
    assign credit_err   = err_q;

endmodule

// File: tb/tb_simple_router_sched.sv
// Scoreboard bench for simple_router_sched. The bench has a credit/round-robin reference model, directed scenarios and a random phase.
module tb_simple_router_sched;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int CR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_data;
    logic [N*2-1:0]    req_addr;
    logic [3:0]        credit_return;
    logic [DW-1:0]     sched_din;
    logic              sched_din_en;
    logic [1:0]        sched_addr;
    logic [1:0]        grant_id;
    logic [15:0]       credit_cnt;
    logic              credit_err;

    simple_router_sched #(.DATA_WIDTH(DW), .NUM_REQ(N), .CREDITS(CR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_addr(req_addr), .credit_return(credit_return),
        .sched_din(sched_din), .sched_din_en(sched_din_en), .sched_addr(sched_addr),
        .grant_id(grant_id), .credit_cnt(credit_cnt), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  addr;
        logic [1:0]  id;
    } beat_t;

    int          checks   = 0;
    int          failures = 0;
    beat_t       expQ[$];
    int          mCred[4];
    int          mPtr;
    bit          mErr;
    int          lastGrant;
    logic [31:0] tbData[N];
    logic [1:0]  tbAddr[N];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first requester after the last winner that is valid and has credit.
    function automatic int modelArbitrate(input logic [3:0] v);
        int i;
        for (int off = 1; off <= N; off++) begin
            i = (mPtr + off) % N;
            if (v[i] && mCred[tbAddr[i]] > 0) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 4; k++) mCred[k] = CR;
        mPtr = N - 1;
        mErr = 1'b0;
    endtask

    // One clock cycle: drive inputs, check combinational/credit state, advance the model.
    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0] ret);
        int          g;
        logic [3:0]  expReady;
        logic [15:0] expCnt;
        beat_t       b;
        bit          inc;
        bit          dec;
        rst           = r;
        req_valid     = v;
        credit_return = ret;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = tbData[i];
            req_addr[i*2 +: 2]   = tbAddr[i];
        end
        g        = r ? modelArbitrate(v) : -1;
        expReady = (g >= 0) ? 4'(1 << g) : 4'b0;
        for (int k = 0; k < 4; k++) expCnt[k*4 +: 4] = 4'(mCred[k]);
        @(negedge clk);
        checkOutput("req_ready", req_ready, expReady);
        checkOutput("credit_cnt", credit_cnt, expCnt);
        checkOutput("credit_err", credit_err, mErr);
        if (!r) begin
            modelReset();
        end else begin
            if (g >= 0) begin
                b.data = tbData[g];
                b.addr = tbAddr[g];
                b.id   = 2'(g);
                expQ.push_back(b);
                mPtr = g;
            end
            for (int k = 0; k < 4; k++) begin
                inc = ret[k];
                dec = (g >= 0) && (tbAddr[g] == 2'(k));
                if (inc && !dec) begin
                    if (mCred[k] == CR) mErr = 1'b1;
                    else mCred[k]++;
                end else if (dec && !inc) begin
                    mCred[k]--;
                end
            end
        end
        lastGrant = g;
        @(posedge clk);
        #1;
    endtask

    task automatic restoreCredits();
        logic [3:0] ret;
        do begin
            ret = '0;
            for (int k = 0; k < 4; k++) if (mCred[k] < CR) ret[k] = 1'b1;
            if (ret != 0) applyStimulus(1'b1, 4'b0, ret);
        end while (ret != 0);
    endtask

    // Monitor: pops the expected beat whenever the DUT drives din_en.
    initial begin
        logic  rstSeen;
        logic  [1:0] holdAddr;
        logic  [1:0] holdId;
        beat_t b;
        holdAddr = '0;
        holdId   = '0;
        forever begin
            @(posedge clk);
            rstSeen = rst;
            @(negedge clk);
            if (!rstSeen) begin
                holdAddr = '0;
                holdId   = '0;
                checkOutput("rst_din_en", sched_din_en, 0);
                checkOutput("rst_din", sched_din, 0);
                checkOutput("rst_addr", sched_addr, 0);
                checkOutput("rst_grant_id", grant_id, 0);
            end else if (sched_din_en === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", sched_din_en, 0);
                end else begin
                    b = expQ.pop_front();
                    checkOutput("beat_din", sched_din, b.data);
                    checkOutput("beat_addr", sched_addr, b.addr);
                    checkOutput("beat_grant_id", grant_id, b.id);
                    holdAddr = b.addr;
                    holdId   = b.id;
                end
            end else begin
                checkOutput("idle_din_en", sched_din_en, 0);
                checkOutput("idle_din", sched_din, 0);
                checkOutput("idle_addr_hold", sched_addr, holdAddr);
                checkOutput("idle_id_hold", grant_id, holdId);
            end
        end
    end

    initial begin
        logic [3:0] ret;
        logic [3:0] rv;
        int         n;
        rst = 1'b0; req_valid = '0; credit_return = '0; req_data = '0; req_addr = '0;
        for (int i = 0; i < N; i++) begin tbData[i] = '0; tbAddr[i] = '0; end
        modelReset();
        lastGrant = -1;
        #1;

        // Reset then idle
        applyStimulus(1'b0, 4'b0, 4'b0);
        applyStimulus(1'b0, 4'b0, 4'b0);
        applyStimulus(1'b1, 4'b0, 4'b0);
        checkOutput("post_reset_din_en", sched_din_en, 0);
        checkOutput("post_reset_din", sched_din, 0);
        checkOutput("post_reset_credits", credit_cnt, 16'h4444);
        checkOutput("post_reset_err", credit_err, 0);

        // Round-robin fairness with credit returned one cycle after each beat
        for (int i = 0; i < N; i++) begin tbAddr[i] = 2'(i); tbData[i] = $urandom; end
        ret = '0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, 4'hF, ret);
            ret = (lastGrant >= 0) ? 4'(1 << tbAddr[lastGrant]) : 4'b0;
            if (lastGrant >= 0) tbData[lastGrant] = $urandom;
        end
        applyStimulus(1'b1, 4'b0, ret);
        restoreCredits();

        // Credit exhaustion on output 2
        n = 0;
        tbAddr[0] = 2'd2;
        tbData[0] = 32'hA5A5_0000;
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, 4'b0001, 4'b0);
            if (lastGrant == 0) begin n++; tbData[0] = 32'hA5A5_0000 + n; end
        end
        checkOutput("exhaust_cnt", credit_cnt[11:8], 0);
        checkOutput("exhaust_ready", req_ready, 0);
        applyStimulus(1'b1, 4'b0001, 4'b0100);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 4'b0001, 4'b0);
            if (lastGrant == 0) begin n++; tbData[0] = 32'hA5A5_0000 + n; end
        end
        restoreCredits();

        // Blocked requester skipped: drain output 1, then req0->1 and req1->3 compete
        tbAddr[0] = 2'd1;
        while (mCred[1] > 0) begin
            applyStimulus(1'b1, 4'b0001, 4'b0);
            tbData[0] = $urandom;
        end
        tbAddr[1] = 2'd3;
        ret = '0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 4'b0011, (c == 5) ? (ret | 4'b0010) : ret);
            ret = (lastGrant >= 0) ? 4'(1 << tbAddr[lastGrant]) : 4'b0;
            if (lastGrant >= 0) tbData[lastGrant] = $urandom;
        end
        applyStimulus(1'b1, 4'b0, ret);
        restoreCredits();

        // Simultaneous decrement and return on output 0 at count 2
        tbAddr[0] = 2'd0;
        applyStimulus(1'b1, 4'b0001, 4'b0);
        tbData[0] = $urandom;
        applyStimulus(1'b1, 4'b0001, 4'b0);
        tbData[0] = $urandom;
        applyStimulus(1'b1, 4'b0001, 4'b0001);
        applyStimulus(1'b1, 4'b0, 4'b0);
        checkOutput("simul_cnt", credit_cnt[3:0], 2);
        restoreCredits();

        // Random traffic, with a reset dropped into the middle
        rv = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] || lastGrant == i) begin
                    rv[i]     = 1'($urandom_range(0, 1));
                    tbData[i] = $urandom;
                    tbAddr[i] = 2'($urandom_range(0, 3));
                end
            end
            ret = '0;
            for (int k = 0; k < 4; k++) if (mCred[k] < CR && $urandom_range(0, 1) == 1) ret[k] = 1'b1;
            applyStimulus((c == 150) ? 1'b0 : 1'b1, rv, ret);
        end
        applyStimulus(1'b1, 4'b0, 4'b0);
        restoreCredits();

        // Overflow on output 3 and sticky error
        applyStimulus(1'b1, 4'b0, 4'b1000);
        checkOutput("ovf_cnt", credit_cnt[15:12], 4);
        checkOutput("ovf_err", credit_err, 1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 4'b0, 4'b0);
        checkOutput("err_sticky", credit_err, 1);
        applyStimulus(1'b0, 4'b0, 4'b0);
        checkOutput("err_cleared", credit_err, 0);
        applyStimulus(1'b1, 4'b0, 4'b0);
        applyStimulus(1'b1, 4'b0, 4'b0);

        checkOutput("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
